// File: rtl/fifo_rd_ctrl.sv
// Read-side sequencer: drains the UART FIFO into uart_tx one byte at a time.
// Optional macro FIFO_RD_STAT_EN adds the tx_byte_cnt counter and flush_evt pulse.

module fifo_rd_ctrl #(
  parameter int unsigned START_LEVEL  = 16,
  parameter int unsigned FLUSH_CYCLES = 50000,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        fifo_empty,
  input  logic [8:0]  fifo_rd_count,
  input  logic [7:0]  fifo_rd_data,
  output logic        fifo_rd_en,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        drain_active
`ifdef FIFO_RD_STAT_EN
  ,
  output logic [15:0] tx_byte_cnt,
  output logic        flush_evt
`endif
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDLE_W = 16;
  localparam int unsigned LAT_W  = 2;

  localparam logic [CNT_W-1:0]  START_LVL = CNT_W'(START_LEVEL);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(FLUSH_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY - 1);

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_RD_REQ   = 5'b00010,
    ST_RD_WAIT  = 5'b00100,
    ST_TX_START = 5'b01000,
    ST_TX_WAIT  = 5'b10000
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [LAT_W-1:0]    w_lat_cnt_nxt;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [IDLE_W-1:0]   w_idle_cnt_nxt;
  logic [DATA_W-1:0]   r_tx_data;
  logic [DATA_W-1:0]   w_tx_data_nxt;
  logic                r_tx_first;
  logic                w_tx_first_nxt;
  logic                r_fifo_rd_en;
  logic                r_tx_start;
  logic                r_drain_active;
  logic                w_level_hit;
  logic                w_timeout;

  // 9-bit compare so a full FIFO (256) meets START_LEVEL=256
  assign w_level_hit = (fifo_rd_count >= START_LVL);
  assign w_timeout   = (r_idle_cnt == IDLE_MAX);

  // Next-state and counter logic
  always_comb begin
    w_state_nxt    = r_state;
    w_lat_cnt_nxt  = r_lat_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_tx_first_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (fifo_empty) begin
          w_idle_cnt_nxt = '0;
        end else if (!w_timeout) begin
          w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
        end
        if (!fifo_empty && !tx_busy && (w_level_hit || w_timeout)) begin
          w_state_nxt    = ST_RD_REQ;
          w_idle_cnt_nxt = '0;
        end
      end
      ST_RD_REQ: begin
        w_state_nxt   = ST_RD_WAIT;
        w_lat_cnt_nxt = '0;
      end
      ST_RD_WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_tx_data_nxt = fifo_rd_data;
          w_lat_cnt_nxt = '0;
          w_state_nxt   = ST_TX_START;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
        end
      end
      ST_TX_START: begin
        w_state_nxt    = ST_TX_WAIT;
        w_tx_first_nxt = 1'b1;
      end
      ST_TX_WAIT: begin
        // uart_tx raises busy a cycle late, so the first cycle is skipped
        if (!r_tx_first && !tx_busy) begin
          w_state_nxt = fifo_empty ? ST_IDLE : ST_RD_REQ;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_lat_cnt_nxt  = '0;
        w_idle_cnt_nxt = '0;
      end
    endcase
  end

  // State register; pulses are decoded from the next state so they are registered
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state        <= ST_IDLE;
      r_lat_cnt      <= '0;
      r_idle_cnt     <= '0;
      r_tx_data      <= '0;
      r_tx_first     <= 1'b0;
      r_fifo_rd_en   <= 1'b0;
      r_tx_start     <= 1'b0;
      r_drain_active <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_lat_cnt      <= w_lat_cnt_nxt;
      r_idle_cnt     <= w_idle_cnt_nxt;
      r_tx_data      <= w_tx_data_nxt;
      r_tx_first     <= w_tx_first_nxt;
      r_fifo_rd_en   <= (w_state_nxt == ST_RD_REQ);
      r_tx_start     <= (w_state_nxt == ST_TX_START);
      r_drain_active <= (w_state_nxt != ST_IDLE);
    end
  end

  assign fifo_rd_en   = r_fifo_rd_en;
  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign drain_active = r_drain_active;

`ifdef FIFO_RD_STAT_EN
  localparam int unsigned STAT_W = 16;

  logic [STAT_W-1:0] r_tx_byte_cnt;
  logic              r_flush_evt;

  // Byte counter tracks tx_start; flush_evt marks timeout-started bursts
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tx_byte_cnt <= '0;
      r_flush_evt   <= 1'b0;
    end else begin
      if (w_state_nxt == ST_TX_START) begin
        r_tx_byte_cnt <= r_tx_byte_cnt + STAT_W'(1);
      end
      r_flush_evt <= (r_state == ST_IDLE) && (w_state_nxt == ST_RD_REQ) && !w_level_hit;
    end
  end

  assign tx_byte_cnt = r_tx_byte_cnt;
  assign flush_evt   = r_flush_evt;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: three instances (threshold 16, threshold 256,
// read latency 2), each with a behavioural FIFO and a 10-cycle-busy uart_tx model.

module tb_fifo_rd_ctrl;

  localparam int NI   = 3;
  localparam int BUSY = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] empty;
  logic [NI-1:0] rd_en;
  logic [NI-1:0] tx_busy;
  logic [NI-1:0] tx_start;
  logic [NI-1:0] drain;
  logic [NI-1:0] wr_en      = '0;
  logic [NI-1:0] busy_force = '0;
  logic [8:0]    count   [NI];
  logic [7:0]    rd_data [NI];
  logic [7:0]    tx_data [NI];
  logic [7:0]    wr_data [NI] = '{default: 8'h00};
`ifdef FIFO_RD_STAT_EN
  logic [15:0]   byte_cnt [NI];
  logic [NI-1:0] flush_evt;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned P_START = (g == 1) ? 256 : 16;
    localparam int unsigned P_FLUSH = (g == 1) ? 1000 : 100;
    localparam int unsigned P_LAT   = (g == 2) ? 2 : 1;

    fifo_rd_ctrl #(
      .START_LEVEL (P_START),
      .FLUSH_CYCLES(P_FLUSH),
      .RD_LATENCY  (P_LAT)
    ) u_dut (
      .sys_clk      (clk),
      .sys_rst_n    (rst_n),
      .fifo_empty   (empty[g]),
      .fifo_rd_count(count[g]),
      .fifo_rd_data (rd_data[g]),
      .fifo_rd_en   (rd_en[g]),
      .tx_busy      (tx_busy[g]),
      .tx_start     (tx_start[g]),
      .tx_data      (tx_data[g]),
      .drain_active (drain[g])
`ifdef FIFO_RD_STAT_EN
      ,
      .tx_byte_cnt  (byte_cnt[g]),
      .flush_evt    (flush_evt[g])
`endif
    );

    // Standard-mode FIFO model (contents survive controller reset)
    logic [7:0] mem [256];
    logic [7:0] wp  = '0;
    logic [7:0] rp  = '0;
    logic [8:0] cnt = '0;
    logic [7:0] p1  = '0;
    logic [7:0] p2  = '0;
    logic       pop;
    assign pop = rd_en[g] && (cnt != 9'd0);
    always @(posedge clk) begin
      if (wr_en[g]) begin
        mem[wp] <= wr_data[g];
        wp      <= wp + 8'd1;
      end
      if (pop) begin
        p1 <= mem[rp];
        rp <= rp + 8'd1;
      end
      p2  <= p1;
      cnt <= cnt + 9'(wr_en[g]) - 9'(pop);
    end
    assign count[g]   = cnt;
    assign empty[g]   = (cnt == 9'd0);
    assign rd_data[g] = (P_LAT == 2) ? p2 : p1;

    // uart_tx model: busy for BUSY cycles starting the cycle after tx_start
    int bcnt = 0;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                bcnt <= 0;
      else if (tx_start[g])      bcnt <= BUSY;
      else if (bcnt != 0)        bcnt <= bcnt - 1;
    end
    assign tx_busy[g] = (bcnt != 0) || busy_force[g];
  end

  int         w_rd_cyc [$];
  int         w_st_cyc [$];
  logic [7:0] w_data   [$];
  int         w_rd_empty;
  int         w_st_busy;
  int         w_flush;
  logic       w_timeout;

  task automatic push_bytes(input int g, input int n, input logic [7:0] base, output int t0);
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      wr_en[g]   = 1'b1;
      wr_data[g] = 8'(base + 8'(i));
      @(negedge clk);
    end
    wr_en[g] = 1'b0;
  endtask

  // Samples one instance each negedge; stops after stop_starts pulses or when the burst ends
  task automatic watch(input int g, input int max_cyc, input int stop_starts);
    logic prev_busy;
    w_rd_cyc.delete();
    w_st_cyc.delete();
    w_data.delete();
    w_rd_empty = 0;
    w_st_busy  = 0;
    w_flush    = 0;
    w_timeout  = 1'b1;
    prev_busy  = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (rd_en[g]) begin
        w_rd_cyc.push_back(cyc);
        if (empty[g]) w_rd_empty++;
      end
      if (tx_start[g]) begin
        w_st_cyc.push_back(cyc);
        w_data.push_back(tx_data[g]);
        if (prev_busy) w_st_busy++;
      end
`ifdef FIFO_RD_STAT_EN
      if (flush_evt[g]) w_flush++;
`endif
      prev_busy = tx_busy[g];
      if (stop_starts != 0 && w_st_cyc.size() == stop_starts) begin
        w_timeout = 1'b0;
        break;
      end
      if (stop_starts == 0 && w_st_cyc.size() > 0 && !drain[g] && empty[g]) begin
        w_timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      n_chk++; if (rd_en[g] !== 1'b0) $display("FAIL reset_rd_en[%0d]: got %b expected 0", g, rd_en[g]); else n_pass++;
      n_chk++; if (tx_start[g] !== 1'b0) $display("FAIL reset_tx_start[%0d]: got %b expected 0", g, tx_start[g]); else n_pass++;
      n_chk++; if (tx_data[g] !== 8'h00) $display("FAIL reset_tx_data[%0d]: got %h expected 00", g, tx_data[g]); else n_pass++;
      n_chk++; if (drain[g] !== 1'b0) $display("FAIL reset_drain[%0d]: got %b expected 0", g, drain[g]); else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_flush_timeout();
    int t0, got, bad;
    push_bytes(0, 15, 8'h30, t0);
    watch(0, 600, 0);
    n_chk++; if (w_timeout) $display("FAIL flush_done: got timeout expected burst end"); else n_pass++;
    got = (w_rd_cyc.size() > 0) ? w_rd_cyc[0] - t0 : -1;
    n_chk++; if (got != 101) $display("FAIL flush_first_rd: got cycle %0d expected 101", got); else n_pass++;
    n_chk++; if (w_st_cyc.size() != 15) $display("FAIL flush_nstart: got %0d expected 15", w_st_cyc.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < w_data.size(); i++) if (w_data[i] !== 8'(8'h30 + 8'(i))) bad++;
    n_chk++; if (bad != 0) $display("FAIL flush_data: got %0d wrong bytes expected 0", bad); else n_pass++;
    n_chk++; if (count[0] !== 9'd0 || drain[0] !== 1'b0) $display("FAIL flush_end: got count %0d drain %b expected 0 0", count[0], drain[0]); else n_pass++;
`ifdef FIFO_RD_STAT_EN
    n_chk++; if (w_flush != 1) $display("FAIL flush_evt: got %0d pulses expected 1", w_flush); else n_pass++;
`endif
  endtask

  task automatic test_threshold_burst();
    int t0, got, bad_gap, bad_dat;
    push_bytes(0, 16, 8'h00, t0);
    watch(0, 600, 0);
    got = (w_rd_cyc.size() > 0) ? w_rd_cyc[0] - t0 : -1;
    n_chk++; if (got != 17) $display("FAIL thr_first_rd: got cycle %0d expected 17", got); else n_pass++;
    n_chk++; if (w_st_cyc.size() != 16 || w_rd_cyc.size() != 16) $display("FAIL thr_count: got %0d starts %0d reads expected 16 16", w_st_cyc.size(), w_rd_cyc.size()); else n_pass++;
    bad_gap = 0;
    bad_dat = 0;
    for (int i = 0; i < w_st_cyc.size() && i < w_rd_cyc.size(); i++) begin
      if (w_st_cyc[i] - w_rd_cyc[i] != 2) bad_gap++;
      if (i > 0 && w_rd_cyc[i] - w_st_cyc[i-1] != BUSY + 2) bad_gap++;
      if (w_data[i] !== 8'(i)) bad_dat++;
    end
    n_chk++; if (bad_gap != 0) $display("FAIL thr_timing: got %0d bad gaps expected 0", bad_gap); else n_pass++;
    n_chk++; if (bad_dat != 0) $display("FAIL thr_data: got %0d wrong bytes expected 0", bad_dat); else n_pass++;
    n_chk++; if (w_rd_empty != 0 || w_st_busy != 0) $display("FAIL thr_guard: got %0d rd-on-empty %0d start-on-busy expected 0 0", w_rd_empty, w_st_busy); else n_pass++;
`ifdef FIFO_RD_STAT_EN
    n_chk++; if (w_flush != 0) $display("FAIL thr_flush_evt: got %0d pulses expected 0", w_flush); else n_pass++;
`endif
  endtask

  task automatic test_full_level();
    int t0, got, bad;
    push_bytes(1, 256, 8'h00, t0);
    watch(1, 5000, 0);
    n_chk++; if (w_timeout) $display("FAIL full_done: got timeout expected burst end"); else n_pass++;
    got = (w_rd_cyc.size() > 0) ? w_rd_cyc[0] - t0 : -1;
    n_chk++; if (got != 257) $display("FAIL full_first_rd: got cycle %0d expected 257", got); else n_pass++;
    n_chk++; if (w_rd_cyc.size() != 256) $display("FAIL full_nread: got %0d expected 256", w_rd_cyc.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < w_data.size(); i++) if (w_data[i] !== 8'(i)) bad++;
    n_chk++; if (bad != 0 || w_data.size() != 256) $display("FAIL full_data: got %0d wrong of %0d expected 0 of 256", bad, w_data.size()); else n_pass++;
    n_chk++; if (w_rd_empty != 0) $display("FAIL full_rd_empty: got %0d expected 0", w_rd_empty); else n_pass++;
  endtask

  task automatic test_rd_latency2();
    int t0, bad_gap, bad_dat;
    push_bytes(2, 16, 8'hA0, t0);
    watch(2, 600, 0);
    n_chk++; if (w_st_cyc.size() != 16) $display("FAIL lat2_nstart: got %0d expected 16", w_st_cyc.size()); else n_pass++;
    bad_gap = 0;
    bad_dat = 0;
    for (int i = 0; i < w_st_cyc.size() && i < w_rd_cyc.size(); i++) begin
      if (w_st_cyc[i] - w_rd_cyc[i] != 3) bad_gap++;
      if (w_data[i] !== 8'(8'hA0 + 8'(i))) bad_dat++;
    end
    n_chk++; if (bad_gap != 0) $display("FAIL lat2_timing: got %0d bad gaps expected 0", bad_gap); else n_pass++;
    n_chk++; if (bad_dat != 0) $display("FAIL lat2_data: got %0d wrong bytes expected 0", bad_dat); else n_pass++;
    n_chk++; if (w_st_busy != 0) $display("FAIL lat2_start_busy: got %0d expected 0", w_st_busy); else n_pass++;
  endtask

  task automatic test_busy_hold();
    int t0, n_rd, n_dr, cr, got, bad;
    @(negedge clk);
    busy_force[0] = 1'b1;
    push_bytes(0, 20, 8'h80, t0);
    n_rd = 0;
    n_dr = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (rd_en[0]) n_rd++;
      if (drain[0]) n_dr++;
    end
    n_chk++; if (n_rd != 0 || n_dr != 0) $display("FAIL hold_idle: got %0d reads %0d drain cycles expected 0 0", n_rd, n_dr); else n_pass++;
    n_chk++; if (count[0] !== 9'd20) $display("FAIL hold_count: got %0d expected 20", count[0]); else n_pass++;
    busy_force[0] = 1'b0;
    cr = cyc;
    watch(0, 600, 0);
    got = (w_rd_cyc.size() > 0) ? w_rd_cyc[0] - cr : -1;
    n_chk++; if (got != 1) $display("FAIL hold_release: got %0d cycles expected 1", got); else n_pass++;
    bad = 0;
    for (int i = 0; i < w_data.size(); i++) if (w_data[i] !== 8'(8'h80 + 8'(i))) bad++;
    n_chk++; if (bad != 0 || w_data.size() != 20) $display("FAIL hold_data: got %0d wrong of %0d expected 0 of 20", bad, w_data.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int t0, r, got, bad;
    push_bytes(0, 16, 8'h50, t0);
    watch(0, 200, 1);
    n_chk++; if (w_data.size() != 1 || w_data[0] !== 8'h50) $display("FAIL rst_first_byte: got %0d bytes expected one 0x50", w_data.size()); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if (tx_data[0] !== 8'h00) $display("FAIL rst_tx_data: got %h expected 00", tx_data[0]); else n_pass++;
    n_chk++; if (drain[0] !== 1'b0 || rd_en[0] !== 1'b0 || tx_start[0] !== 1'b0) $display("FAIL rst_pulses: got drain %b rd %b start %b expected 0 0 0", drain[0], rd_en[0], tx_start[0]); else n_pass++;
`ifdef FIFO_RD_STAT_EN
    n_chk++; if (byte_cnt[0] !== 16'd0) $display("FAIL rst_byte_cnt: got %0d expected 0", byte_cnt[0]); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    watch(0, 600, 0);
    got = (w_rd_cyc.size() > 0) ? w_rd_cyc[0] - r : -1;
    n_chk++; if (got != 100) $display("FAIL rst_resume_rd: got cycle %0d expected 100", got); else n_pass++;
    bad = 0;
    for (int i = 0; i < w_data.size(); i++) if (w_data[i] !== 8'(8'h51 + 8'(i))) bad++;
    n_chk++; if (bad != 0 || w_data.size() != 15) $display("FAIL rst_resume_data: got %0d wrong of %0d expected 0 of 15", bad, w_data.size()); else n_pass++;
`ifdef FIFO_RD_STAT_EN
    n_chk++; if (byte_cnt[0] !== 16'd15) $display("FAIL rst_byte_cnt_end: got %0d expected 15", byte_cnt[0]); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_flush_timeout();
    test_threshold_burst();
    test_full_level();
    test_rd_latency2();
    test_busy_hold();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
